// File: rtl/mmu_tlb.sv
// Small fully associative TLB with FIFO replacement, same-cycle update bypass
// and a saturating miss counter.
module mmu_tlb #(
  parameter int  PAGE_NUM_WIDTH = 20,
  parameter int  ENTRIES        = 4,
  localparam int IDX_W          = $clog2(ENTRIES),
  localparam int OFF_W          = 32 - PAGE_NUM_WIDTH
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      stall,
  input  logic                      mmu_en,
  input  logic                      mmu_update,
  input  logic [PAGE_NUM_WIDTH-1:0] vpage_in,
  input  logic [PAGE_NUM_WIDTH-1:0] ppage_in,
  input  logic                      flush,
  input  logic [31:0]               vaddr_in,
  output logic [31:0]               paddr_o,
  output logic                      mmu_error_o,
  output logic [IDX_W-1:0]          hit_idx_o,
  output logic [15:0]               miss_cnt_o
);

  logic [ENTRIES-1:0]        valid_q, valid_d;
  logic [PAGE_NUM_WIDTH-1:0] vpage_q [ENTRIES];
  logic [PAGE_NUM_WIDTH-1:0] vpage_d [ENTRIES];
  logic [PAGE_NUM_WIDTH-1:0] ppage_q [ENTRIES];
  logic [PAGE_NUM_WIDTH-1:0] ppage_d [ENTRIES];
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic                      en_q, en_d;
  logic [15:0]               miss_q, miss_d;

  logic [PAGE_NUM_WIDTH-1:0] vpn;
  logic [OFF_W-1:0]          off;
  logic                      st_hit, upd_match, byp_hit, hit, en;
  logic [IDX_W-1:0]          st_idx, upd_idx, wr_idx;
  logic [PAGE_NUM_WIDTH-1:0] ppage_hit;

  assign vpn = vaddr_in[31:OFF_W];
  assign off = vaddr_in[OFF_W-1:0];
  assign en  = mmu_update ? mmu_en : en_q;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    st_hit    = 1'b0;
    st_idx    = '0;
    upd_match = 1'b0;
    upd_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && vpage_q[i] == vpn) begin
        st_hit = 1'b1;
        st_idx = IDX_W'(i);
      end
      if (valid_q[i] && vpage_q[i] == vpage_in) begin
        upd_match = 1'b1;
        upd_idx   = IDX_W'(i);
      end
    end
  end

  // A flush empties the table first, so a simultaneous update always lands at 0.
  assign wr_idx    = flush ? '0 : (upd_match ? upd_idx : ptr_q);
  assign byp_hit   = mmu_update && (vpage_in == vpn);
  assign hit       = byp_hit || st_hit;
  assign ppage_hit = byp_hit ? ppage_in : ppage_q[st_idx];
  assign hit_idx_o = byp_hit ? wr_idx : (st_hit ? st_idx : '0);
  assign miss_cnt_o = miss_q;

  always_comb begin
    paddr_o     = vaddr_in;
    mmu_error_o = 1'b0;
    if (en) begin
      if (hit) begin
        paddr_o = {ppage_hit, off};
      end else begin
        paddr_o     = {{PAGE_NUM_WIDTH{1'b0}}, off};
        mmu_error_o = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    vpage_d = vpage_q;
    ppage_d = ppage_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    miss_d  = miss_q;
    if (!stall) begin
      if (flush) begin
        valid_d = '0;
        ptr_d   = '0;
      end
      if (mmu_update) begin
        en_d = mmu_en;
        if (flush || !upd_match) begin
          vpage_d[wr_idx] = vpage_in;
          ppage_d[wr_idx] = ppage_in;
          valid_d[wr_idx] = 1'b1;
          ptr_d           = wr_idx + IDX_W'(1);
        end else begin
          ppage_d[upd_idx] = ppage_in;
        end
      end
      if (mmu_error_o && miss_q != 16'hFFFF) begin
        miss_d = miss_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      ptr_q   <= '0;
      en_q    <= 1'b0;
      miss_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      miss_q  <= miss_d;
    end
  end

  // Page numbers are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    vpage_q <= vpage_d;
    ppage_q <= ppage_d;
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed scenarios, randomized traffic and
// miss-counter saturation, all compared against a table-based reference model.
module tb_mmu_tlb;
  localparam int PW = 20;
  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          clr, stall, mmu_en, mmu_update, flush;
  logic [PW-1:0] vpage_in, ppage_in;
  logic [31:0]   vaddr_in, paddr_o;
  logic          mmu_error_o;
  logic [1:0]    hit_idx_o;
  logic [15:0]   miss_cnt_o;

  mmu_tlb #(.PAGE_NUM_WIDTH(PW), .ENTRIES(NE)) dut (
    .clk(clk), .clr(clr), .stall(stall), .mmu_en(mmu_en),
    .mmu_update(mmu_update), .vpage_in(vpage_in), .ppage_in(ppage_in),
    .flush(flush), .vaddr_in(vaddr_in), .paddr_o(paddr_o),
    .mmu_error_o(mmu_error_o), .hit_idx_o(hit_idx_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: a plain table of translations plus FIFO pointer.
  bit            m_v   [NE];
  logic [PW-1:0] m_vp  [NE];
  logic [PW-1:0] m_pp  [NE];
  int            m_ptr;
  bit            m_en;
  int            m_miss;
  logic [31:0]   e_paddr;
  bit            e_err, e_en;
  int            e_idx;

  function automatic int find(input logic [PW-1:0] v);
    for (int i = 0; i < NE; i++)
      if (m_v[i] && m_vp[i] == v) return i;
    return -1;
  endfunction

  function automatic void model_out();
    logic [PW-1:0] vpn = vaddr_in[31:32-PW];
    logic [31-PW:0] off = vaddr_in[31-PW:0];
    logic [PW-1:0] pp = '0;
    bit hit = 0;
    int k;
    e_en  = mmu_update ? mmu_en : m_en;
    e_idx = 0;
    if (mmu_update && vpage_in == vpn) begin
      hit = 1; pp = ppage_in;
      k = find(vpage_in);
      e_idx = flush ? 0 : (k >= 0 ? k : m_ptr);
    end else begin
      k = find(vpn);
      if (k >= 0) begin hit = 1; pp = m_pp[k]; e_idx = k; end
    end
    if (!e_en) begin e_paddr = vaddr_in; e_err = 0; end
    else if (hit) begin e_paddr = {pp, off}; e_err = 0; end
    else begin e_paddr = {{PW{1'b0}}, off}; e_err = 1; end
  endfunction

  function automatic void model_edge();
    int k;
    if (clr) begin
      for (int i = 0; i < NE; i++) m_v[i] = 0;
      m_ptr = 0; m_en = 0; m_miss = 0;
      return;
    end
    if (stall) return;
    if (e_err && m_miss < 65535) m_miss++;
    if (flush) begin
      for (int i = 0; i < NE; i++) m_v[i] = 0;
      m_ptr = 0;
    end
    if (mmu_update) begin
      m_en = mmu_en;
      k = find(vpage_in);
      if (k >= 0) m_pp[k] = ppage_in;
      else begin
        m_v[m_ptr] = 1; m_vp[m_ptr] = vpage_in; m_pp[m_ptr] = ppage_in;
        m_ptr = (m_ptr + 1) % NE;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle against the model, then advance one edge.
  task automatic settle();
    #4;
    model_out();
    chk("paddr", paddr_o, e_paddr);
    chk("error", 32'(mmu_error_o), 32'(e_err));
    chk("miss_cnt", 32'(miss_cnt_o), 32'(m_miss));
    if (!mmu_update && e_en) chk("hit_idx", 32'(hit_idx_o), 32'(e_idx));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic upd(input bit en, input logic [PW-1:0] v, input logic [PW-1:0] p);
    mmu_update = 1; mmu_en = en; vpage_in = v; ppage_in = p;
    settle(); tick();
    mmu_update = 0;
  endtask

  int m0;

  initial begin
    clr = 1; stall = 0; mmu_en = 0; mmu_update = 0; flush = 0;
    vpage_in = '0; ppage_in = '0; vaddr_in = '0;
    tick();
    clr = 0;

    // Reset state: pass-through, no error, counter clear.
    vaddr_in = 32'h1234_5678;
    settle();
    chk("rst_paddr", paddr_o, 32'h1234_5678);
    chk("rst_err", 32'(mmu_error_o), 32'd0);
    chk("rst_idx", 32'(hit_idx_o), 32'd0);
    chk("rst_miss", 32'(miss_cnt_o), 32'd0);
    tick();

    // Bypass on the update cycle, stored entry afterwards.
    mmu_update = 1; mmu_en = 1; vpage_in = 20'h12345; ppage_in = 20'h00ABC;
    settle();
    chk("byp_paddr", paddr_o, 32'h00AB_C678);
    tick();
    mmu_update = 0;
    settle();
    chk("stored_paddr", paddr_o, 32'h00AB_C678);
    chk("stored_idx", 32'(hit_idx_o), 32'd0);
    tick();

    // FIFO replacement: five writes into four entries.
    flush = 1; settle(); tick(); flush = 0;
    vaddr_in = 32'h0000_0ABC;
    for (int i = 1; i <= 5; i++) upd(1, PW'(i), PW'(32'h100 + i));
    vaddr_in = 32'h0000_1ABC;
    settle();
    chk("evict_err", 32'(mmu_error_o), 32'd1);
    chk("evict_paddr", paddr_o, 32'h0000_0ABC);
    tick();
    vaddr_in = 32'h0000_5ABC;
    settle();
    chk("wrap_idx", 32'(hit_idx_o), 32'd0);
    chk("wrap_paddr", paddr_o, 32'h0010_5ABC);
    tick();

    // Rewrite of an existing vpage keeps the pointer.
    upd(1, 20'h3, 20'h777);
    vaddr_in = 32'h0000_3ABC;
    settle();
    chk("rewrite_paddr", paddr_o, 32'h0077_7ABC);
    chk("rewrite_idx", 32'(hit_idx_o), 32'd2);
    tick();
    upd(1, 20'h6, 20'h606);
    vaddr_in = 32'h0000_6001;
    settle();
    chk("ptr_kept_idx", 32'(hit_idx_o), 32'd1);
    tick();

    // Flush plus update in one cycle.
    m0 = m_miss;
    vaddr_in = 32'h0000_9123;
    flush = 1; upd(1, 20'h9, 20'h8); flush = 0;
    settle();
    chk("fu_paddr", paddr_o, 32'h0000_8123);
    chk("fu_idx", 32'(hit_idx_o), 32'd0);
    chk("fu_miss", 32'(miss_cnt_o), 32'(m0));
    tick();
    vaddr_in = 32'h0000_5ABC;
    settle();
    chk("fu_other_err", 32'(mmu_error_o), 32'd1);
    tick();
    upd(1, 20'hA, 20'hA0);
    vaddr_in = 32'h0000_A000;
    settle();
    chk("fu_ptr_idx", 32'(hit_idx_o), 32'd1);
    tick();

    // Kernel mode, then a stalled update that must still bypass.
    upd(0, 20'hB, 20'hB0);
    vaddr_in = 32'h0000_9123;
    settle();
    chk("kern_paddr", paddr_o, 32'h0000_9123);
    tick();
    stall = 1; mmu_update = 1; mmu_en = 1; vpage_in = 20'hC; ppage_in = 20'hC0;
    vaddr_in = 32'h0000_C345;
    settle();
    chk("stall_byp", paddr_o, 32'h000C_0345);
    tick();
    stall = 0; mmu_update = 0;
    settle();
    chk("stall_noen", paddr_o, 32'h0000_C345);
    tick();

    // Randomized traffic, including mid-operation resets.
    for (int n = 0; n < 800; n++) begin
      clr        = ($urandom_range(0, 99) < 2);
      stall      = ($urandom_range(0, 99) < 10);
      flush      = ($urandom_range(0, 99) < 5);
      mmu_update = ($urandom_range(0, 99) < 35);
      mmu_en     = ($urandom_range(0, 99) < 80);
      vpage_in   = PW'($urandom_range(0, 7));
      ppage_in   = PW'($urandom);
      if ($urandom_range(0, 9) == 0) vaddr_in = $urandom;
      else vaddr_in = ($urandom_range(0, 7) << 12) | ($urandom & 32'hFFF);
      settle(); tick();
    end
    clr = 0; stall = 0; flush = 0; mmu_update = 0;

    // Saturation with a stall burst.
    clr = 1; settle(); tick(); clr = 0;
    vaddr_in = 32'h0000_1000;
    upd(1, 20'h1, 20'h2);
    vaddr_in = 32'h0005_5ABC;
    for (int i = 0; i < 70000; i++) begin
      stall = (i >= 100 && i < 110);
      settle();
      if (i == 110) chk("stall_hold_miss", 32'(miss_cnt_o), 32'd100);
      tick();
    end
    stall = 0;
    settle();
    chk("sat_miss", 32'(miss_cnt_o), 32'hFFFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 Parameter PAGE_NUM_WIDTH, default 20: page-number width; offset width is 32-PAGE_NUM_WIDTH; legal range 8..28.
REQ-002 Parameter ENTRIES, default 4: number of translation entries; power of two, 2..16; IDX_W = log2(ENTRIES).
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port clr  in  1: reset, synchronous, active-high.
REQ-005 Port stall  in  1: when high, blocks every state update except clr.
REQ-006 Port mmu_en  in  1: translation enable to be latched (1 = user mode, 0 = kernel mode).
REQ-007 Port mmu_update  in  1: write request; installs vpage_in->ppage_in and latches mmu_en.
REQ-008 Port vpage_in, ppage_in  in  PAGE_NUM_WIDTH each: entry written on an update.
REQ-009 Port flush  in  1: invalidates all entries.
REQ-010 Port vaddr_in  in  32: virtual address to translate.
REQ-011 Port paddr_o  out  32: translated physical address.
REQ-012 Port mmu_error_o  out  1: translation miss while enabled.
REQ-013 Port hit_idx_o  out  IDX_W: index of the matching entry; 0 when there is no hit.
REQ-014 Port miss_cnt_o  out  16: saturating count of miss cycles.

Function
REQ-015 Per-entry state SHALL be valid bit, vpage and ppage; global state SHALL be en_reg, fill pointer ptr (IDX_W bits) and miss counter.
REQ-016 Effective controls SHALL be combinational: en = mmu_update ? mmu_en : en_reg.
- Same-cycle bypass: when mmu_update=1, the entry {vpage_in, ppage_in} SHALL take part in the lookup with priority over stored entries.
REQ-017 Lookup SHALL be fully associative, zero-latency combinational on vaddr_in[31:32-PAGE_NUM_WIDTH] against valid entries.
- If multiple entries match, the lowest index SHALL win.
REQ-018 Hit with en=1: paddr_o = {ppage_hit, vaddr_in offset}; mmu_error_o = 0.
REQ-019 Miss with en=1: mmu_error_o = 1; paddr_o = {PAGE_NUM_WIDTH zeros, offset}.
REQ-020 en=0: paddr_o = vaddr_in; mmu_error_o = 0, regardless of entry contents.
REQ-021 Update (mmu_update & ~stall), vpage_in not matching any valid entry: SHALL write entry[ptr], set valid, ptr <= ptr+1 wrapping modulo ENTRIES (FIFO replacement), en_reg <= mmu_en.
REQ-022 Update with vpage_in matching valid entry k: SHALL overwrite only ppage of entry k; ptr SHALL be unchanged (no duplicate entries ever).
REQ-023 Flush (flush & ~stall): all valid bits <= 0, ptr <= 0; en_reg and miss counter SHALL be unchanged.
REQ-024 Flush and update in the same cycle: the flush applies first; the new entry SHALL be written to index 0 with valid=1, ptr <= 1, en_reg <= mmu_en.
REQ-025 Miss counter SHALL increment by 1 on each cycle with mmu_error_o=1 and stall=0, saturate at 0xFFFF, and be unaffected by flush.
REQ-026 stall=1: no change to entries, ptr, en_reg or counter; combinational outputs (including bypass) SHALL still be driven.

Reset
REQ-027 clr=1 at a rising edge SHALL clear all valid bits, set ptr=0, en_reg=0 and miss counter=0, overriding stall, flush and mmu_update.
REQ-028 After reset with mmu_update=0: paddr_o = vaddr_in, mmu_error_o=0, hit_idx_o=0, miss_cnt_o=0.
REQ-029 clr asserted mid-operation (entries valid, ptr≠0) SHALL take effect at that edge with no residual entry state.

Verification
REQ-030 Reset, then drive vaddr 0x1234_5678 with mmu_update=0 -> paddr_o=0x1234_5678, error=0, miss_cnt_o=0.
REQ-031 Update {en=1, v=0x12345, p=0x00ABC} -> same cycle paddr_o=0x00AB_C678 via bypass; next cycle, with no update, identical output, hit_idx_o=0.
REQ-032 Write five distinct vpages 0x1..0x5 (ENTRIES=4) -> entry 0 holds 0x5 and vpage 0x1 misses (error=1, paddr_o=0x0000_0xxx with offset kept); ptr=1.
REQ-033 Rewrite vpage 0x3 with new ppage 0x777 -> ptr unchanged, only entry for 0x3 updated, translation of 0x0000_3ABC gives 0x0077_7ABC.
REQ-034 Flush and update {v=0x9, p=0x8} in the same cycle -> all other entries miss, 0x9 hits at index 0, ptr=1; miss_cnt_o unchanged by the flush.
REQ-035 Hold a missing address with en=1 for 70000 cycles, stall pulsed for 10 of them -> miss_cnt_o=0xFFFF saturated, with no increment on stalled cycles before saturation.
